// File: rtl/jpeg_bitstream_unstuffer.sv
// JPEG entropy front end: removes 0xFF/0x00 stuffing, reports markers and
// exposes a left-aligned bit window. Optional JPEG_UNSTUFF_RST_EN clears the window on RSTn ack.
module jpeg_bitstream_unstuffer #(
    parameter int BUF_W = 32,
    parameter int MAXC  = 16,
    localparam int CW   = $clog2(BUF_W + 1),
    localparam int KW   = $clog2(MAXC + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [MAXC-1:0] win,
    output logic [CW-1:0]   win_bits,
    input  logic [KW-1:0]   consume,
    output logic            marker_valid,
    output logic [7:0]      marker_code,
    input  logic            marker_ack,
    output logic            err
`ifdef JPEG_UNSTUFF_RST_EN
    ,
    output logic            rst_seen
`endif
);

    typedef enum logic [1:0] {S_DATA, S_FF, S_MARK} state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               mark_q, mark_d;
    logic [7:0]         code_q, code_d;
    logic               err_q, err_d;

    logic               accept;
    logic               append;
    logic [7:0]         app_byte;
    logic               illegal;
    logic [KW-1:0]      keep;
    logic [CW-1:0]      base;
    logic               clr_buf;

    assign in_ready     = (state_q != S_MARK) && (cnt_q <= CW'(BUF_W - 8));
    assign accept       = in_valid && in_ready;
    assign win          = buf_q[BUF_W-1 -: MAXC];
    assign win_bits     = cnt_q;
    assign marker_valid = mark_q;
    assign marker_code  = code_q;
    assign err          = err_q;

    // Stuffing / marker recognition
    always_comb begin
        state_d  = state_q;
        mark_d   = mark_q;
        code_d   = code_q;
        append   = 1'b0;
        app_byte = in_data;
        clr_buf  = 1'b0;
        unique case (state_q)
            S_DATA: begin
                if (accept) begin
                    if (in_data == 8'hFF) state_d = S_FF;
                    else                  append  = 1'b1;
                end
            end
            S_FF: begin
                if (accept) begin
                    if (in_data == 8'h00) begin
                        append   = 1'b1;
                        app_byte = 8'hFF;
                        state_d  = S_DATA;
                    end else if (in_data != 8'hFF) begin
                        mark_d  = 1'b1;
                        code_d  = in_data;
                        state_d = S_MARK;
                    end
                end
            end
            S_MARK: begin
                if (marker_ack) begin
                    mark_d  = 1'b0;
                    state_d = S_DATA;
`ifdef JPEG_UNSTUFF_RST_EN
                    clr_buf = (code_q[7:3] == 5'b11010);
`endif
                end
            end
            default: state_d = S_DATA;
        endcase
    end

`ifdef JPEG_UNSTUFF_RST_EN
    assign rst_seen = clr_buf;
`endif

    // Window shift and append; an illegal consume leaves the window in place
    always_comb begin
        illegal = (32'(consume) > 32'(cnt_q)) || (32'(consume) > MAXC);
        keep    = illegal ? '0 : consume;
        err_d   = err_q | illegal;
        base    = cnt_q - CW'(keep);
        buf_d   = buf_q << keep;
        cnt_d   = base;
        if (append) begin
            buf_d = buf_d | ({app_byte, {(BUF_W-8){1'b0}}} >> base);
            cnt_d = base + CW'(8);
        end
        if (clr_buf) begin
            buf_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_DATA;
            buf_q   <= '0;
            cnt_q   <= '0;
            mark_q  <= 1'b0;
            code_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            mark_q  <= mark_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_jpeg_bitstream_unstuffer.sv
// Bench for jpeg_bitstream_unstuffer: directed cases plus randomized traffic
// against a bit-queue model of the unstuffing rules.
module tb_jpeg_bitstream_unstuffer;
    localparam int BUF_W = 32;
    localparam int MAXC  = 16;
    localparam int CW    = $clog2(BUF_W + 1);
    localparam int KW    = $clog2(MAXC + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [MAXC-1:0] win;
    logic [CW-1:0]   win_bits;
    logic [KW-1:0]   consume = '0;
    logic            marker_valid;
    logic [7:0]      marker_code;
    logic            marker_ack = 1'b0;
    logic            err;
`ifdef JPEG_UNSTUFF_RST_EN
    logic            rst_seen;
`endif

    jpeg_bitstream_unstuffer #(.BUF_W(BUF_W), .MAXC(MAXC)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .win(win), .win_bits(win_bits), .consume(consume),
        .marker_valid(marker_valid), .marker_code(marker_code),
        .marker_ack(marker_ack), .err(err)
`ifdef JPEG_UNSTUFF_RST_EN
        , .rst_seen(rst_seen)
`endif
    );

    always #5 clk = ~clk;

    int pass_n = 0;
    int tot_n  = 0;
    int rdy_cnt;

    // Model: queue of buffered bits (front = oldest) plus stream flags
    bit       mq[$];
    bit       m_ff, m_mk, m_err;
    bit [7:0] m_code;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [MAXC-1:0] m_win();
        logic [MAXC-1:0] w = '0;
        for (int i = 0; i < MAXC; i++)
            if (i < mq.size()) w[MAXC-1-i] = mq[i];
        return w;
    endfunction

    function automatic bit m_rdy();
        return !m_mk && (mq.size() <= BUF_W - 8);
    endfunction

    task automatic check_all();
        chk("win", win, m_win());
        chk("win_bits", win_bits, mq.size());
        chk("in_ready", in_ready, m_rdy());
        chk("marker_valid", marker_valid, m_mk);
        chk("marker_code", marker_code, m_code);
        chk("err", err, m_err);
    endtask

    task automatic model_step(input bit v, input bit [7:0] d, input int c, input bit a);
        bit acc    = v && m_rdy();
        bit was_mk = m_mk;
        if (c > mq.size() || c > MAXC) m_err = 1;
        else repeat (c) void'(mq.pop_front());
        if (acc) begin
            if (!m_ff) begin
                if (d == 8'hFF) m_ff = 1;
                else for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
            end else if (d == 8'h00) begin
                for (int i = 0; i < 8; i++) mq.push_back(1'b1);
                m_ff = 0;
            end else if (d != 8'hFF) begin
                m_mk = 1; m_code = d; m_ff = 0;
            end
        end
        if (was_mk && a) begin
            m_mk = 0;
`ifdef JPEG_UNSTUFF_RST_EN
            if (m_code >= 8'hD0 && m_code <= 8'hD7) mq.delete();
`endif
        end
    endtask

    // One cycle: compare registered outputs, drive inputs, advance model, move to next negedge
    task automatic tick(input bit v, input bit [7:0] d, input int c, input bit a);
        check_all();
        if (in_ready) rdy_cnt++;
        in_valid = v; in_data = d; consume = KW'(c); marker_ack = a;
`ifdef JPEG_UNSTUFF_RST_EN
        #1;
        chk("rst_seen", rst_seen,
            m_mk && a && (m_code >= 8'hD0) && (m_code <= 8'hD7));
`endif
        model_step(v, d, c, a);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 0; in_data = 0; consume = 0; marker_ack = 0;
        mq.delete(); m_ff = 0; m_mk = 0; m_err = 0; m_code = 0;
        @(posedge clk); #1;
        chk("rst_win_bits", win_bits, 0);
        chk("rst_marker_valid", marker_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk("reset_win", win, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_err", err, 0);
        chk("reset_marker_code", marker_code, 0);

        // Plain bytes
        tick(1, 8'h12, 0, 0); tick(1, 8'h34, 0, 0); tick(1, 8'h56, 0, 0);
        chk("plain_bits", win_bits, 24);
        chk("plain_win", win, 16'h1234);
        chk("model_plain_bits", mq.size(), 24);
        chk("model_plain_win", m_win(), 16'h1234);
        check_all();

        // Stuffed 0xFF
        do_reset();
        tick(1, 8'hFF, 0, 0); tick(1, 8'h00, 0, 0); tick(1, 8'hAB, 0, 0);
        chk("stuff_bits", win_bits, 16);
        chk("stuff_win", win, 16'hFFAB);
        chk("stuff_marker", marker_valid, 0);
        chk("model_stuff_win", m_win(), 16'hFFAB);

        // Marker with fill byte
        do_reset();
        tick(1, 8'hAB, 0, 0); tick(1, 8'hFF, 0, 0); tick(1, 8'hFF, 0, 0); tick(1, 8'hD9, 0, 0);
        chk("mark_valid", marker_valid, 1);
        chk("mark_code", marker_code, 8'hD9);
        chk("mark_ready", in_ready, 0);
        chk("mark_bits", win_bits, 8);
        tick(1, 8'h77, 0, 0); tick(1, 8'h77, 0, 0);
        chk("mark_hold_ready", in_ready, 0);
        tick(0, 8'h00, 0, 1);
        chk("ack_valid", marker_valid, 0);
        chk("ack_ready", in_ready, 1);
        chk("ack_bits", win_bits, 8);

        // Legal then illegal consume
        do_reset();
        tick(1, 8'h12, 0, 0); tick(1, 8'h34, 0, 0);
        tick(0, 8'h00, 5, 0);
        chk("cons_bits", win_bits, 11);
        chk("cons_win", win, 16'h4680);
        tick(0, 8'h00, 12, 0);
        chk("illegal_bits", win_bits, 11);
        chk("illegal_err", err, 1);
        tick(0, 8'h00, 0, 0); tick(0, 8'h00, 3, 0);
        chk("err_sticky", err, 1);

        // Fill to BUF_W
        do_reset();
        tick(1, 8'h11, 0, 0); tick(1, 8'h22, 0, 0); tick(1, 8'h33, 0, 0); tick(1, 8'h44, 0, 0);
        chk("full_bits", win_bits, 32);
        chk("full_ready", in_ready, 0);
        tick(1, 8'h55, 0, 0);
        chk("full_hold_bits", win_bits, 32);
        chk("full_win", win, 16'h1122);

        // Sustained 1 byte/cycle with consume 8
        do_reset();
        tick(1, 8'h11, 0, 0);
        rdy_cnt = 0;
        for (int i = 0; i < 40; i++) tick(1, 8'h5A, 8, 0);
        chk("thru_accepts", rdy_cnt, 40);
        chk("thru_bits", win_bits, 8);
        chk("thru_win", win, 16'h5A00);

        // RSTn marker
        do_reset();
        tick(1, 8'h12, 0, 0); tick(1, 8'h34, 0, 0); tick(0, 8'h00, 3, 0);
        chk("rstn_pre_bits", win_bits, 13);
        tick(1, 8'hFF, 0, 0); tick(1, 8'hD3, 0, 0);
        chk("rstn_code", marker_code, 8'hD3);
        tick(0, 8'h00, 0, 1);
`ifdef JPEG_UNSTUFF_RST_EN
        chk("rstn_bits", win_bits, 0);
`else
        chk("rstn_bits", win_bits, 13);
`endif
        check_all();

        // Randomized traffic with periodic resets (some mid-marker)
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            bit       v, a;
            bit [7:0] d;
            int       c, r, lim;
            if (n % 700 == 699) do_reset();
            v = ($urandom % 4) != 0;
            r = $urandom % 10;
            if (r < 2)       d = 8'hFF;
            else if (r == 2) d = 8'h00;
            else if (r == 3) d = 8'hD0 + 8'($urandom % 16);
            else             d = 8'($urandom);
            lim = (mq.size() < MAXC) ? mq.size() : MAXC;
            if ($urandom % 40 == 0) c = $urandom % (MAXC + 4);
            else                    c = $urandom_range(0, lim);
            a = m_mk ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
            tick(v, d, c, a);
        end
        check_all();

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
